// File: rtl/fire_scheduler.sv
// fire_scheduler: double-buffered activity bitfield with priority-ordered drain.
//
// Producers mark indices in an accumulate bank during a timestep. A swap moves the
// accumulate bank into a drain bank. The drain bank is then emitted one index per
// cycle over a valid/ready handshake, lowest or highest index first. A one-cycle
// done pulse follows the end of every drain epoch, including an empty one.
//
// Parameters:
//   WIDTH     number of tracked indices (>= 2, any value)
//   LSB_FIRST 1: lowest set index first, 0: highest set index first
//   IDX_W     derived index width, not meant to be overridden
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   set_valid    mark set_idx in the accumulate bank this cycle
//   set_idx      index to mark; values >= WIDTH are ignored
//   swap         request to move the accumulate bank into the drain bank
//   swap_ready   high in IDLE, when a swap is accepted
//   flush        synchronous clear of both banks; overrides everything else
//   out_valid    out_idx holds a pending drain index
//   out_idx      index on offer, 0 when out_valid is low
//   out_ready    consumer accepts out_idx
//   done         one-cycle pulse after a drain epoch finishes
//   busy         high while draining
//   pending_cnt  set bits left in the drain bank (only with FIRE_SCHED_COUNT_EN)
//
// Optional feature: define FIRE_SCHED_COUNT_EN to add the pending_cnt output.

module fire_scheduler #(
  parameter int unsigned  WIDTH     = 16,
  parameter int unsigned  LSB_FIRST = 1,
  localparam int unsigned IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_valid,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             swap,
  output logic             swap_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic             done,
  output logic             busy
`ifdef FIRE_SCHED_COUNT_EN
  ,
  output logic [IDX_W:0]   pending_cnt
`endif
);

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   drain_q, drain_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   set_vec;
  logic [WIDTH-1:0]   clr_vec;
  logic [IDX_W-1:0]   enc_idx;

  // One-hot of the incoming set; indices >= WIDTH match no bit and drop out here.
  always_comb begin
    set_vec = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      set_vec[i] = set_valid && (set_idx == IDX_W'(i));
    end
  end

  // Priority encode of the registered drain bank. The last match in loop order
  // wins, so the loop direction selects which end of the bank has priority.
  always_comb begin
    enc_idx = '0;
    if (LSB_FIRST != 0) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (drain_q[i]) enc_idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (drain_q[i]) enc_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    clr_vec = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      clr_vec[i] = (enc_idx == IDX_W'(i));
    end
  end

`ifdef FIRE_SCHED_COUNT_EN
  logic [IDX_W:0] cnt_q, cnt_d;

  function automatic logic [IDX_W:0] popcnt(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction
`endif

  always_comb begin
    acc_d   = acc_q | set_vec;
    drain_d = drain_q;
    state_d = state_q;
    done_d  = 1'b0;
`ifdef FIRE_SCHED_COUNT_EN
    cnt_d   = cnt_q;
`endif
    if (flush) begin
      acc_d   = '0;
      drain_d = '0;
      state_d = StIdle;
`ifdef FIRE_SCHED_COUNT_EN
      cnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (swap) begin
            // A set arriving in the swap cycle belongs to the epoch being closed.
            drain_d = acc_q | set_vec;
            acc_d   = '0;
`ifdef FIRE_SCHED_COUNT_EN
            cnt_d   = popcnt(drain_d);
`endif
            if (|drain_d) begin
              state_d = StDrain;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StDrain: begin
          // Swap is ignored here; new sets only reach the accumulate bank.
          if (out_ready) begin
            drain_d = drain_q & ~clr_vec;
`ifdef FIRE_SCHED_COUNT_EN
            cnt_d   = cnt_q - (IDX_W + 1)'(1);
`endif
            if (drain_d == '0) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

`ifdef FIRE_SCHED_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;
`endif

  assign out_valid  = (state_q == StDrain);
  assign out_idx    = out_valid ? enc_idx : '0;
  assign busy       = (state_q == StDrain);
  assign swap_ready = (state_q == StIdle);
  assign done       = done_q;

endmodule

// File: tb/tb_fire_scheduler.sv
// Bench for fire_scheduler. Two instances share one stimulus stream:
//   A: WIDTH=20, LSB_FIRST=1 (5-bit index, 20..31 out of range)
//   B: WIDTH=13, LSB_FIRST=0 (4-bit index, 13..15 out of range)
// The reference model keeps each bank as a plain bit set and derives the offered
// index arithmetically. Every cycle the stimulus pushes the expected outputs of
// each instance into a queue; a monitor pops and compares them.

module tb_fire_scheduler;

  localparam int WA = 20;
  localparam int WB = 13;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_idx = '0;
  logic       swap = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;

  logic       a_swap_ready, a_out_valid, a_done, a_busy;
  logic [4:0] a_out_idx;
  logic       b_swap_ready, b_out_valid, b_done, b_busy;
  logic [3:0] b_out_idx;
`ifdef FIRE_SCHED_COUNT_EN
  logic [5:0] a_cnt;
  logic [4:0] b_cnt;
`endif

  always #5 clk = ~clk;

  fire_scheduler #(.WIDTH(WA), .LSB_FIRST(1)) u_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_valid  (set_valid),
    .set_idx    (set_idx),
    .swap       (swap),
    .swap_ready (a_swap_ready),
    .flush      (flush),
    .out_valid  (a_out_valid),
    .out_idx    (a_out_idx),
    .out_ready  (out_ready),
    .done       (a_done),
    .busy       (a_busy)
`ifdef FIRE_SCHED_COUNT_EN
    ,
    .pending_cnt(a_cnt)
`endif
  );

  fire_scheduler #(.WIDTH(WB), .LSB_FIRST(0)) u_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_valid  (set_valid),
    .set_idx    (set_idx[3:0]),
    .swap       (swap),
    .swap_ready (b_swap_ready),
    .flush      (flush),
    .out_valid  (b_out_valid),
    .out_idx    (b_out_idx),
    .out_ready  (out_ready),
    .done       (b_done),
    .busy       (b_busy)
`ifdef FIRE_SCHED_COUNT_EN
    ,
    .pending_cnt(b_cnt)
`endif
  );

  typedef struct {
    bit valid;
    int idx;
    bit done;
    int cnt;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] acc_m   [2];
  logic [31:0] drain_m [2];
  bit          done_m  [2];

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, want);
    end
  endtask

  // Next index to emit: isolate the lowest set bit, or take floor(log2) for highest.
  function automatic int front(input logic [31:0] v, input int d);
    if (d == 0) return $clog2(v & (~v + 32'd1));
    return $clog2(v + 32'd1) - 1;
  endfunction

  task automatic step(input bit sv, input int si, input bit sw, input bit fl,
                      input bit rdy, input bit rs);
    exp_t        e;
    logic [31:0] sb;
    int          ix;
    int          w;
    bit          nd;
    @(negedge clk);
    #1;
    set_valid = sv;
    set_idx   = 5'(si);
    swap      = sw;
    flush     = fl;
    out_ready = rdy;
    reset_n   = !rs;
    for (int d = 0; d < 2; d++) begin
      w  = (d == 0) ? WA : WB;
      ix = (d == 0) ? (si & 31) : (si & 15);
      if (rs) begin
        e.valid    = 1'b0;
        e.idx      = 0;
        e.done     = 1'b0;
        e.cnt      = 0;
        acc_m[d]   = '0;
        drain_m[d] = '0;
        done_m[d]  = 1'b0;
      end else begin
        e.valid = (drain_m[d] != 0);
        e.idx   = e.valid ? front(drain_m[d], d) : 0;
        e.done  = done_m[d];
        e.cnt   = $countones(drain_m[d]);
        sb      = (sv && ix < w) ? (32'd1 << ix) : 32'd0;
        nd      = 1'b0;
        if (fl) begin
          acc_m[d]   = '0;
          drain_m[d] = '0;
        end else if (e.valid) begin
          if (rdy) begin
            drain_m[d] = drain_m[d] & ~(32'd1 << e.idx);
            nd = (drain_m[d] == 0);
          end
          acc_m[d] = acc_m[d] | sb;
        end else if (sw) begin
          drain_m[d] = acc_m[d] | sb;
          acc_m[d]   = '0;
          nd = (drain_m[d] == 0);
        end else begin
          acc_m[d] = acc_m[d] | sb;
        end
        done_m[d] = nd;
      end
      if (d == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
  endtask

  task automatic set1(input int si);
    step(1'b1, si, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Monitor: sampled 2 ns after the falling edge, once this cycle's inputs are set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow at %0t: got empty want record", $time);
      end else begin
        e = exp_q0.pop_front();
        chk("a_out_valid", int'(a_out_valid), int'(e.valid));
        chk("a_out_idx", int'(a_out_idx), e.idx);
        chk("a_done", int'(a_done), int'(e.done));
        chk("a_busy", int'(a_busy), int'(e.valid));
        chk("a_swap_ready", int'(a_swap_ready), int'(!e.valid));
`ifdef FIRE_SCHED_COUNT_EN
        chk("a_pending_cnt", int'(a_cnt), e.cnt);
`endif
        e = exp_q1.pop_front();
        chk("b_out_valid", int'(b_out_valid), int'(e.valid));
        chk("b_out_idx", int'(b_out_idx), e.idx);
        chk("b_done", int'(b_done), int'(e.done));
        chk("b_busy", int'(b_busy), int'(e.valid));
        chk("b_swap_ready", int'(b_swap_ready), int'(!e.valid));
`ifdef FIRE_SCHED_COUNT_EN
        chk("b_pending_cnt", int'(b_cnt), e.cnt);
`endif
      end
    end
  end

  initial begin
    // Reset held for two cycles.
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2, 1'b0);

    // 3, 9, 15 drained back to back.
    set1(3); set1(9); set1(15);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(6, 1'b1);

    // Consumer stalls with an index on offer.
    set1(9); set1(15); set1(3);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1, 1'b1);
    run(4, 1'b0);
    run(4, 1'b1);

    // Empty epoch, then a set in the swap cycle itself.
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(2, 1'b0);
    step(1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    run(3, 1'b1);

    // Swap and set during a drain: swap ignored, 2 held for the next epoch.
    set1(5); set1(6);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    run(4, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(3, 1'b1);

    // Flush mid-drain, then an empty swap.
    set1(5); set1(6);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    run(2, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(2, 1'b1);

    // Out-of-range indices.
    set1(20); set1(31); set1(14);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(3, 1'b1);

    // Async reset in the middle of a drain.
    set1(0); set1(1); set1(2); set1(3);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(2, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(3, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 45,
           int'($urandom_range(0, 31)),
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 599) == 0);
    end
    run(40, 1'b1);

    #2;
    chk("a_scoreboard_left", exp_q0.size(), 0);
    chk("b_scoreboard_left", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
